// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one operand bit per clock.
// Optional two's-complement input; ovf flags a magnitude that does not fit in DIGITS digits.
module bin2bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int DW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state, state_next;
    logic [BIN_W-1:0]  sh;
    logic [BIN_W-1:0]  mag;
    logic [DW-1:0]     dig;
    logic [DW-1:0]     adj;
    logic              sign;
    logic              sign_in;
    logic              sticky;
    logic [CW-1:0]     cnt;

    always_comb begin
        sign_in = (SIGNED != 0) && bin[BIN_W-1];
        mag     = sign_in ? (~bin + BIN_W'(1)) : bin;
    end

    // Per-digit add-3 correction; digits never carry into each other.
    always_comb begin
        adj = '0;
        for (int k = 0; k < DIGITS; k++) begin
            adj[4*k +: 4] = (dig[4*k +: 4] >= 4'd5) ? dig[4*k +: 4] + 4'd3 : dig[4*k +: 4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh     <= '0;
            dig    <= '0;
            sign   <= 1'b0;
            sticky <= 1'b0;
            cnt    <= '0;
            bcd    <= '0;
            neg    <= 1'b0;
            ovf    <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        sh     <= mag;
                        sign   <= sign_in;
                        dig    <= '0;
                        sticky <= 1'b0;
                        cnt    <= CW'(BIN_W);
                    end
                end
                SHIFT: begin
                    // The top digit's bit 3 falls off the end: that is a carry past 10^DIGITS.
                    dig    <= {adj[DW-2:0], sh[BIN_W-1]};
                    sh     <= {sh[BIN_W-2:0], 1'b0};
                    sticky <= sticky | adj[DW-1];
                    cnt    <= cnt - CW'(1);
                end
                DONE: begin
                    bcd <= dig;
                    neg <= sign;
                    ovf <= sticky;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: three instances cover default,
// signed 8-bit/3-digit and 12-bit/3-digit overflow configurations.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 0, start_b = 0, start_c = 0;
    logic [11:0] bin_a = 0, bin_c = 0;
    logic [7:0]  bin_b = 0;
    logic        busy_a, busy_b, busy_c, valid_a, valid_b, valid_c;
    logic        neg_a, neg_b, neg_c, ovf_a, ovf_b, ovf_c;
    logic [15:0] bcd_a;
    logic [11:0] bcd_b, bcd_c;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a), .busy(busy_a),
        .valid(valid_a), .bcd(bcd_a), .neg(neg_a), .ovf(ovf_a));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b), .busy(busy_b),
        .valid(valid_b), .bcd(bcd_b), .neg(neg_b), .ovf(ovf_b));
    bin2bcd_seq #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .bin(bin_c), .busy(busy_c),
        .valid(valid_c), .bcd(bcd_c), .neg(neg_c), .ovf(ovf_c));

    function automatic logic sel_valid(input int d);
        return (d == 0) ? valid_a : (d == 1) ? valid_b : valid_c;
    endfunction

    function automatic logic sel_busy(input int d);
        return (d == 0) ? busy_a : (d == 1) ? busy_b : busy_c;
    endfunction

    // One conversion on instance d; lat = edges after the accept edge until valid shows.
    task automatic conv(input int d, input logic [11:0] v, output int lat, output int bc,
                        output logic [15:0] res, output logic n, output logic o);
        @(negedge clk);
        case (d)
            0: begin start_a = 1; bin_a = v; end
            1: begin start_b = 1; bin_b = v[7:0]; end
            default: begin start_c = 1; bin_c = v; end
        endcase
        @(posedge clk);
        lat = 0;
        bc  = 0;
        while (lat < 50) begin
            @(negedge clk);
            start_a = 0; start_b = 0; start_c = 0;
            if (sel_valid(d)) break;
            if (sel_busy(d)) bc++;
            lat++;
        end
        case (d)
            0: begin res = bcd_a; n = neg_a; o = ovf_a; end
            1: begin res = {4'h0, bcd_b}; n = neg_b; o = ovf_b; end
            default: begin res = {4'h0, bcd_c}; n = neg_c; o = ovf_c; end
        endcase
    endtask

    task automatic test_reset;
        rst = 1;
        #12;
        checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
        checks++; if (bcd_a !== 16'h0)  begin errors++; $display("FAIL reset_bcd got %h want 0000", bcd_a); end
        checks++; if (neg_a !== 1'b0)   begin errors++; $display("FAIL reset_neg got %b want 0", neg_a); end
        checks++; if (ovf_a !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_max;
        int lat, bc; logic [15:0] r; logic n, o;
        conv(0, 12'd4095, lat, bc, r, n, o);
        checks++; if (lat !== 13)     begin errors++; $display("FAIL max_latency got %0d want 13", lat); end
        checks++; if (bc !== 13)      begin errors++; $display("FAIL max_busy_cycles got %0d want 13", bc); end
        checks++; if (r !== 16'h4095) begin errors++; $display("FAIL max_bcd got %h want 4095", r); end
        checks++; if (o !== 1'b0)     begin errors++; $display("FAIL max_ovf got %b want 0", o); end
        checks++; if (n !== 1'b0)     begin errors++; $display("FAIL max_neg got %b want 0", n); end
    endtask

    task automatic test_zero_thousand;
        int lat, bc; logic [15:0] r; logic n, o;
        conv(0, 12'd0, lat, bc, r, n, o);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL zero_bcd got %h want 0000", r); end
        conv(0, 12'd1000, lat, bc, r, n, o);
        checks++; if (r !== 16'h1000) begin errors++; $display("FAIL thousand_bcd got %h want 1000", r); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bin_a = 12'($urandom);
            checks++;
            if (bcd_a !== 16'h1000 || valid_a !== 1'b0) begin
                errors++; $display("FAIL hold_outputs got bcd=%h valid=%b want bcd=1000 valid=0", bcd_a, valid_a);
            end
        end
    endtask

    task automatic test_signed;
        int lat, bc; logic [15:0] r; logic n, o;
        conv(1, 12'h080, lat, bc, r, n, o);
        checks++; if (lat !== 9)                      begin errors++; $display("FAIL s80_latency got %0d want 9", lat); end
        checks++; if (r !== 16'h0128 || n !== 1'b1)   begin errors++; $display("FAIL s80 got bcd=%h neg=%b want 0128 1", r, n); end
        checks++; if (o !== 1'b0)                     begin errors++; $display("FAIL s80_ovf got %b want 0", o); end
        conv(1, 12'h0FF, lat, bc, r, n, o);
        checks++; if (r !== 16'h0001 || n !== 1'b1)   begin errors++; $display("FAIL sff got bcd=%h neg=%b want 0001 1", r, n); end
        conv(1, 12'h07F, lat, bc, r, n, o);
        checks++; if (r !== 16'h0127 || n !== 1'b0)   begin errors++; $display("FAIL s7f got bcd=%h neg=%b want 0127 0", r, n); end
    endtask

    task automatic test_overflow;
        int lat, bc; logic [15:0] r; logic n, o;
        conv(2, 12'd999, lat, bc, r, n, o);
        checks++; if (r !== 16'h0999 || o !== 1'b0) begin errors++; $display("FAIL o999 got bcd=%h ovf=%b want 0999 0", r, o); end
        conv(2, 12'd1000, lat, bc, r, n, o);
        checks++; if (r !== 16'h0000 || o !== 1'b1) begin errors++; $display("FAIL o1000 got bcd=%h ovf=%b want 0000 1", r, o); end
        conv(2, 12'd4095, lat, bc, r, n, o);
        checks++; if (r !== 16'h0095 || o !== 1'b1) begin errors++; $display("FAIL o4095 got bcd=%h ovf=%b want 0095 1", r, o); end
    endtask

    task automatic test_ignore_start;
        int vcount = 0;
        logic [15:0] seen = 16'hFFFF;
        @(negedge clk);
        start_a = 1; bin_a = 12'd123;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3 || k == 7) begin start_a = 1; bin_a = 12'd456; end
            else start_a = 0;
            if (valid_a) begin vcount++; seen = bcd_a; end
        end
        start_a = 0;
        checks++; if (vcount !== 1)      begin errors++; $display("FAIL ignore_valid_count got %0d want 1", vcount); end
        checks++; if (seen !== 16'h0123) begin errors++; $display("FAIL ignore_bcd got %h want 0123", seen); end
    endtask

    task automatic test_back_to_back;
        int k;
        @(negedge clk);
        start_a = 1; bin_a = 12'd321;
        @(posedge clk);
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            start_a = 0;
            if (valid_a) break;
            k++;
        end
        checks++; if (bcd_a !== 16'h0321) begin errors++; $display("FAIL b2b_first got %h want 0321", bcd_a); end
        start_a = 1; bin_a = 12'd2000;
        @(posedge clk);
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            start_a = 0;
            if (valid_a) break;
            k++;
        end
        checks++; if (k !== 13)           begin errors++; $display("FAIL b2b_latency got %0d want 13", k); end
        checks++; if (bcd_a !== 16'h2000) begin errors++; $display("FAIL b2b_second got %h want 2000", bcd_a); end
    endtask

    task automatic test_reset_mid;
        int lat, bc; logic [15:0] r; logic n, o;
        int vcount = 0;
        @(negedge clk);
        start_a = 1; bin_a = 12'd2748;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_a = 0;
        end
        #2 rst = 1;
        #1;
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || bcd_a !== 16'h0 || neg_a !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got busy=%b valid=%b bcd=%h neg=%b ovf=%b want all 0",
                     busy_a, valid_a, bcd_a, neg_a, ovf_a);
        end
        repeat (3) @(negedge clk);
        rst = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (valid_a) vcount++;
        end
        checks++; if (vcount !== 0) begin errors++; $display("FAIL rst_no_valid got %0d want 0", vcount); end
        conv(0, 12'd2748, lat, bc, r, n, o);
        checks++; if (r !== 16'h2748 || lat !== 13) begin errors++; $display("FAIL rst_restart got bcd=%h lat=%0d want 2748 13", r, lat); end
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero_thousand();
        test_signed();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
